audio_sample_conditioner: RTL and testbench
===========================================

// Module: audio_sample_conditioner
// PURPOSE
//  Downstream of the panner/mixer. Takes the 11-bit unsigned left/right mix and
//  produces 16-bit signed samples for the M2M audio path at SAMPLE_HZ.
//  Per channel: clk-rate 1st-order low-pass (anti-alias), then decimation on a
//  fractional-rate sample tick, a DC-blocking high-pass, gain and saturation.
// PARAMETERS
//  CLK_HZ      28000000  core clock frequency in Hz
//  SAMPLE_HZ   48000     output sample rate in Hz, < CLK_HZ
//  LP_SHIFT    4         low-pass coefficient 2^-LP_SHIFT; 0 = bypass (y = x)
//  DC_SHIFT    10        DC-tracker coefficient 2^-DC_SHIFT, range 1..15
//  GAIN_SHIFT  4         left shift applied after DC removal, range 0..8
// PORTS
//  clk          in   1   core clock
//  mrst         in   1   synchronous reset, active-high
//  mix_left     in   11  unsigned left mix, sampled every clk
//  mix_right    in   11  unsigned right mix, sampled every clk
//  mute         in   1   force sample outputs to 0; filters keep running
//  sample_left  out  16  signed left sample, held between strobes
//  sample_right out  16  signed right sample, held between strobes
//  sample_valid out  1   one-clk strobe: new sample pair on outputs
// BEHAVIOUR
//  Reset: all outputs 0, filter states 0, phase accumulator 0, FSM in PRIME.
//  Tick gen: 32-bit acc; each clk acc+=SAMPLE_HZ; when result >= CLK_HZ,
//   acc<=result-CLK_HZ and tick=1 that clk. Long-run tick rate exactly SAMPLE_HZ.
//  Low-pass (every clk): lp <= lp + ((x<<LP_SHIFT) - lp) >>> LP_SHIFT, lp width
//   11+LP_SHIFT unsigned; filtered value xf = lp[top 11 bits] (truncate).
//  Pipeline from tick at clk T:
//   T+1 S1: smp <= xf (both channels captured in same clk).
//   T+2 S2: diff <= smp - dc_int (signed 12b, -2047..2047); dc update:
//        dc <= dc + ((smp<<DC_SHIFT) - dc) >>> DC_SHIFT; dc_int = dc>>DC_SHIFT
//        (value before update used for diff).
//   T+3 S3: y = diff <<< GAIN_SHIFT, saturate to [-32768, 32767]; outputs
//        <= mute ? 0 : y; sample_valid=1 for this clk only.
//   Latency tick -> sample_valid = 3 clk; fully pipelined, one sample per tick.
//  FSM PRIME/RUN:
//   PRIME: first tick after reset runs S1, then at S2 loads dc <= smp<<DC_SHIFT
//    (diff forced 0), produces no strobe, goes RUN. Prevents start-up thump.
//   RUN: every tick produces exactly one sample_valid; stays RUN until mrst.
//  Boundaries:
//   mrst mid-pipeline: in-flight samples discarded, no strobe in following clk,
//    outputs 0, back to PRIME.
//   tick while previous sample in flight: impossible when CLK_HZ/SAMPLE_HZ>=3;
//    required ratio >= 3 (checked by simulation assertion).
//   mute toggles only affect S3 output mux; dc/lp tracking unaffected; strobe
//    still generated while muted.
//   Saturation only reachable for GAIN_SHIFT>4; arithmetic widths must not wrap.
// TESTING (LP_SHIFT=0, CLK_HZ=100, SAMPLE_HZ=10 unless noted)
//  1 Reset: hold mrst 5 clk with random mix -> outputs 0, sample_valid 0;
//    first tick after release gives no strobe (PRIME).
//  2 Tick rate: run 1000 clk -> exactly 100 strobes, spaced 10 clk, each 3 clk
//    after the tick; CLK_HZ=100,SAMPLE_HZ=30 -> 300 strobes per 1000 clk.
//  3 DC: constant mix 1024 both channels -> every RUN sample = 0.
//  4 Step: prime at 0, then mix_left=2047 -> left samples 32752, 32736, ...
//    decaying monotonically toward 0; right stays 0 with mix_right=0.
//  5 Saturation: GAIN_SHIFT=8, prime 0, step to 2047 -> +32767; step to 0 from
//    settled 2047 -> -32768.
//  6 Mute/reset mid-op: mute=1 -> strobes continue, samples 0, after unmute
//    samples match unmuted reference run; mrst at S2 -> no strobe, re-PRIME.

Source files
------------

// File: rtl/audio_sample_conditioner_if.sv
// Mix inputs and conditioned sample outputs of the audio sample conditioner.
// master = mixer side / consumer of samples, slave = the conditioner itself.
interface audio_sample_conditioner_if;
  logic [10:0] mix_left;
  logic [10:0] mix_right;
  logic        mute;
  logic [15:0] sample_left;
  logic [15:0] sample_right;
  logic        sample_valid;

  modport master (
    output mix_left, mix_right, mute,
    input  sample_left, sample_right, sample_valid
  );

  modport slave (
    input  mix_left, mix_right, mute,
    output sample_left, sample_right, sample_valid
  );
endinterface

// File: rtl/audio_sample_conditioner.sv
// Audio sample conditioner: per-channel clk-rate low-pass, fractional-rate
// decimation, DC-blocking high-pass, gain and saturation to signed 16-bit.
//
// state | meaning
// PRIME | waiting for the first decimated sample; it seeds the DC tracker, no strobe
// RUN   | every tick yields one sample pair three clocks later
module audio_sample_conditioner #(
  parameter int unsigned CLK_HZ     = 28000000,
  parameter int unsigned SAMPLE_HZ  = 48000,
  parameter int unsigned LP_SHIFT   = 4,   // 0..15
  parameter int unsigned DC_SHIFT   = 10,  // 1..15
  parameter int unsigned GAIN_SHIFT = 4    // 0..8
) (
  input logic                       clk,
  input logic                       mrst,
  audio_sample_conditioner_if.slave bus
);
  localparam int LPW = 11 + LP_SHIFT;
  localparam int DCW = 11 + DC_SHIFT;
  localparam int YW  = 20;  // 12-bit diff shifted by up to 8, plus headroom
  localparam logic signed [YW-1:0] Y_MAX = 32767;
  localparam logic signed [YW-1:0] Y_MIN = -32768;

  typedef enum logic {PRIME, RUN} state_t;

  // s + ((x << sh) - s) >>> sh in a 28-bit signed frame so nothing wraps for sh <= 15
  function automatic logic signed [27:0] track(logic signed [27:0] s, logic [10:0] x,
                                               int unsigned sh);
    logic signed [27:0] xs;
    xs = 28'(x) << sh;
    return s + ((xs - s) >>> sh);
  endfunction

  function automatic logic signed [11:0] dc_diff(logic [10:0] smp, logic [DCW-1:0] dc);
    return $signed({1'b0, smp}) - $signed({1'b0, dc[DCW-1 -: 11]});
  endfunction

  function automatic logic [15:0] gain_sat(logic signed [11:0] d);
    logic signed [YW-1:0] y;
    y = YW'(d) <<< GAIN_SHIFT;
    if (y > Y_MAX)      return 16'h7fff;
    else if (y < Y_MIN) return 16'h8000;
    else                return y[15:0];
  endfunction

  logic [31:0]        acc_q, acc_d;
  logic [32:0]        acc_sum;
  logic               tick;
  logic [LPW-1:0]     lp_l_q, lp_l_d, lp_r_q, lp_r_d;
  logic [10:0]        smp_l_q, smp_l_d, smp_r_q, smp_r_d;
  logic [DCW-1:0]     dc_l_q, dc_l_d, dc_r_q, dc_r_d;
  logic signed [11:0] diff_l_q, diff_l_d, diff_r_q, diff_r_d;
  logic               s1_q, s1_d, s2_q, s2_d;
  logic [15:0]        out_l_q, out_l_d, out_r_q, out_r_d;
  logic               valid_q, valid_d;
  state_t             state_q, state_d;

  // Next-state logic: tick generator, low-pass, three-stage sample pipeline, FSM
  always_comb begin
    acc_sum = {1'b0, acc_q} + 33'(SAMPLE_HZ);
    tick    = (acc_sum >= 33'(CLK_HZ));
    acc_d   = tick ? 32'(acc_sum - 33'(CLK_HZ)) : acc_sum[31:0];

    lp_l_d = LPW'(track(28'(lp_l_q), bus.mix_left, LP_SHIFT));
    lp_r_d = LPW'(track(28'(lp_r_q), bus.mix_right, LP_SHIFT));

    s1_d    = tick;
    smp_l_d = tick ? lp_l_q[LPW-1 -: 11] : smp_l_q;
    smp_r_d = tick ? lp_r_q[LPW-1 -: 11] : smp_r_q;

    s2_d     = 1'b0;
    dc_l_d   = dc_l_q;
    dc_r_d   = dc_r_q;
    diff_l_d = diff_l_q;
    diff_r_d = diff_r_q;
    state_d  = state_q;
    if (s1_q) begin
      if (state_q == PRIME) begin
        // Seed the tracker with the first sample so the output starts at zero
        dc_l_d   = DCW'(smp_l_q) << DC_SHIFT;
        dc_r_d   = DCW'(smp_r_q) << DC_SHIFT;
        diff_l_d = '0;
        diff_r_d = '0;
        state_d  = RUN;
      end else begin
        diff_l_d = dc_diff(smp_l_q, dc_l_q);
        diff_r_d = dc_diff(smp_r_q, dc_r_q);
        dc_l_d   = DCW'(track(28'(dc_l_q), smp_l_q, DC_SHIFT));
        dc_r_d   = DCW'(track(28'(dc_r_q), smp_r_q, DC_SHIFT));
        s2_d     = 1'b1;
      end
    end

    valid_d = s2_q;
    out_l_d = out_l_q;
    out_r_d = out_r_q;
    if (s2_q) begin
      out_l_d = bus.mute ? 16'h0000 : gain_sat(diff_l_q);
      out_r_d = bus.mute ? 16'h0000 : gain_sat(diff_r_q);
    end
  end

  // State registers; reset drops any sample in flight and returns to PRIME
  always_ff @(posedge clk) begin
    if (mrst) begin
      acc_q    <= '0;
      lp_l_q   <= '0;
      lp_r_q   <= '0;
      smp_l_q  <= '0;
      smp_r_q  <= '0;
      dc_l_q   <= '0;
      dc_r_q   <= '0;
      diff_l_q <= '0;
      diff_r_q <= '0;
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      out_l_q  <= '0;
      out_r_q  <= '0;
      valid_q  <= 1'b0;
      state_q  <= PRIME;
    end else begin
      // A new tick must never land on a sample still in the pipeline (ratio >= 3)
      assert (!(tick && (s1_q || s2_q)));
      acc_q    <= acc_d;
      lp_l_q   <= lp_l_d;
      lp_r_q   <= lp_r_d;
      smp_l_q  <= smp_l_d;
      smp_r_q  <= smp_r_d;
      dc_l_q   <= dc_l_d;
      dc_r_q   <= dc_r_d;
      diff_l_q <= diff_l_d;
      diff_r_q <= diff_r_d;
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      out_l_q  <= out_l_d;
      out_r_q  <= out_r_d;
      valid_q  <= valid_d;
      state_q  <= state_d;
    end
  end

  assign bus.sample_left  = out_l_q;
  assign bus.sample_right = out_r_q;
  assign bus.sample_valid = valid_q;
endmodule

// File: tb/tb_audio_sample_conditioner.sv
// Bench for audio_sample_conditioner: two instances (10 and 30 samples per
// 100 clk, gain shift 4 and 8) checked every clock against a sample-level model.
module tb_audio_sample_conditioner;
  localparam int CLK = 100;
  localparam int DCS = 10;
  localparam int LPS = 0;
  int sh_hz [2] = '{10, 30};
  int gain  [2] = '{4, 8};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst  [2];
  logic [10:0] mixl [2];
  logic [10:0] mixr [2];
  logic        mute [2];
  logic               obs_v [2];
  logic signed [15:0] ol [2];
  logic signed [15:0] orr [2];

  audio_sample_conditioner_if ifa ();
  audio_sample_conditioner_if ifb ();
  assign ifa.mix_left = mixl[0];
  assign ifa.mix_right = mixr[0];
  assign ifa.mute = mute[0];
  assign ifb.mix_left = mixl[1];
  assign ifb.mix_right = mixr[1];
  assign ifb.mute = mute[1];
  assign obs_v[0] = ifa.sample_valid;
  assign obs_v[1] = ifb.sample_valid;
  assign ol[0] = ifa.sample_left;
  assign ol[1] = ifb.sample_left;
  assign orr[0] = ifa.sample_right;
  assign orr[1] = ifb.sample_right;

  audio_sample_conditioner #(.CLK_HZ(100), .SAMPLE_HZ(10), .LP_SHIFT(0), .DC_SHIFT(10),
    .GAIN_SHIFT(4)) dut_a (.clk(clk), .mrst(rst[0]), .bus(ifa));
  audio_sample_conditioner #(.CLK_HZ(100), .SAMPLE_HZ(30), .LP_SHIFT(0), .DC_SHIFT(10),
    .GAIN_SHIFT(8)) dut_b (.clk(clk), .mrst(rst[1]), .bus(ifb));

  // Reference model: per-clock phase accumulator and filters; each tick computes
  // its finished sample at once and schedules it for the clock it must appear.
  typedef struct {int d; int due; int yl; int yr;} pend_t;
  pend_t pq[$];
  int  macc [2], lpl [2], lpr [2], dcl [2], dcr [2];
  bit  primed [2], mtick [2];
  int  exp_v [2], exp_l [2], exp_r [2];
  int  cyc, n_cmp, n_bad;

  function automatic int sat16(int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  task automatic model_edge(input int d);
    int sum, xl, xr, dfl, dfr;
    pend_t p;
    mtick[d] = 0;
    if (rst[d]) begin
      macc[d] = 0; lpl[d] = 0; lpr[d] = 0; dcl[d] = 0; dcr[d] = 0;
      primed[d] = 0; exp_v[d] = 0; exp_l[d] = 0; exp_r[d] = 0;
      for (int i = pq.size() - 1; i >= 0; i--) if (pq[i].d == d) pq.delete(i);
      return;
    end
    exp_v[d] = 0;
    for (int i = 0; i < pq.size(); i++) begin
      if (pq[i].d == d && pq[i].due == cyc) begin
        exp_v[d] = 1;
        exp_l[d] = mute[d] ? 0 : pq[i].yl;
        exp_r[d] = mute[d] ? 0 : pq[i].yr;
        pq.delete(i);
        break;
      end
    end
    sum = macc[d] + sh_hz[d];
    if (sum >= CLK) begin
      macc[d] = sum - CLK;
      mtick[d] = 1;
      xl = lpl[d] >>> LPS;
      xr = lpr[d] >>> LPS;
      if (!primed[d]) begin
        dcl[d] = xl <<< DCS;
        dcr[d] = xr <<< DCS;
        primed[d] = 1;
      end else begin
        dfl = xl - (dcl[d] >>> DCS);
        dfr = xr - (dcr[d] >>> DCS);
        dcl[d] = dcl[d] + (((xl <<< DCS) - dcl[d]) >>> DCS);
        dcr[d] = dcr[d] + (((xr <<< DCS) - dcr[d]) >>> DCS);
        p.d = d; p.due = cyc + 2;
        p.yl = sat16(dfl * (1 << gain[d]));
        p.yr = sat16(dfr * (1 << gain[d]));
        pq.push_back(p);
      end
    end else begin
      macc[d] = sum;
    end
    lpl[d] = lpl[d] + (((int'(mixl[d]) <<< LPS) - lpl[d]) >>> LPS);
    lpr[d] = lpr[d] + (((int'(mixr[d]) <<< LPS) - lpr[d]) >>> LPS);
  endtask

  task automatic chk(input string tag, input int d, input logic signed [31:0] obs,
                     input logic signed [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s dut%0d cycle %0d: observed %0d expected %0d", tag, d, cyc, obs, expv);
    end
  endtask

  task automatic cycle();
    model_edge(0);
    model_edge(1);
    @(posedge clk);
    #1;
    cyc++;
    for (int d = 0; d < 2; d++) begin
      chk("valid", d, 32'(obs_v[d]), exp_v[d]);
      chk("left", d, 32'(ol[d]), exp_l[d]);
      chk("right", d, 32'(orr[d]), exp_r[d]);
    end
  endtask

  task automatic wait_strobe(input int d, output logic signed [31:0] val, output int ok);
    val = 'x;
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      cycle();
      if (obs_v[d] === 1'b1) begin
        val = 32'(ol[d]);
        ok = 1;
        break;
      end
    end
  endtask

  logic signed [31:0] v, prev;
  int ok, ca, cb, last_a, found;

  initial begin
    n_cmp = 0; n_bad = 0; cyc = 0;
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; mute[d] = 1'b0;
      mixl[d] = 11'($urandom_range(0, 2047));
      mixr[d] = 11'($urandom_range(0, 2047));
      macc[d] = 0; lpl[d] = 0; lpr[d] = 0; dcl[d] = 0; dcr[d] = 0;
      primed[d] = 0; mtick[d] = 0; exp_v[d] = 0; exp_l[d] = 0; exp_r[d] = 0;
    end
    repeat (5) cycle();
    chk("reset_valid", 0, 32'(obs_v[0]), 0);
    chk("reset_left", 1, 32'(ol[1]), 0);

    // Constant mid-scale input: PRIME suppresses the first tick, then all zero
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b0; mixl[d] = 11'd1024; mixr[d] = 11'd1024;
    end
    ca = 0;
    repeat (20) begin cycle(); if (obs_v[0]) ca++; end
    chk("prime_no_strobe", 0, ca, 0);
    ca = 0; cb = 0; last_a = -1;
    repeat (1000) begin
      cycle();
      if (obs_v[0]) begin
        ca++;
        if (last_a >= 0) chk("gap", 0, cyc - last_a, 10);
        last_a = cyc;
        chk("dc_zero_l", 0, 32'(ol[0]), 0);
        chk("dc_zero_r", 0, 32'(orr[0]), 0);
      end
      if (obs_v[1]) begin
        cb++;
        chk("dc_zero_l", 1, 32'(ol[1]), 0);
      end
    end
    chk("rate", 0, ca, 100);
    chk("rate", 1, cb, 300);

    // Step on the left channel after priming at zero
    rst[0] = 1'b1; mixl[0] = 11'd0; mixr[0] = 11'd0;
    repeat (2) cycle();
    rst[0] = 1'b0;
    repeat (15) cycle();
    mixl[0] = 11'd2047;
    wait_strobe(0, v, ok);
    chk("step_seen", 0, ok, 1);
    chk("step_first", 0, v, 32752);
    chk("step_right", 0, 32'(orr[0]), 0);
    wait_strobe(0, v, ok);
    chk("step_second", 0, v, 32736);
    for (int i = 0; i < 4; i++) begin
      prev = v;
      wait_strobe(0, v, ok);
      chk("step_decay", 0, 32'((ok == 1) && (v < prev) && (v > 0)), 1);
      chk("step_right", 0, 32'(orr[0]), 0);
    end

    // Saturation on the gain-8 instance, both polarities
    for (int pol = 0; pol < 2; pol++) begin
      rst[1] = 1'b1;
      mixl[1] = (pol == 0) ? 11'd0 : 11'd2047;
      mixr[1] = mixl[1];
      repeat (2) cycle();
      rst[1] = 1'b0;
      repeat (15) cycle();
      mixl[1] = (pol == 0) ? 11'd2047 : 11'd0;
      repeat (3) wait_strobe(1, v, ok);
      chk("sat_seen", 1, ok, 1);
      chk(pol == 0 ? "sat_pos" : "sat_neg", 1, v, (pol == 0) ? 32767 : -32768);
      chk("sat_right", 1, 32'(orr[1]), 0);
    end

    // Mute: strobes keep coming with zero samples; tracking continues underneath
    mute[0] = 1'b1;
    ca = 0;
    repeat (100) begin
      mixl[0] = 11'($urandom_range(0, 2047));
      mixr[0] = 11'($urandom_range(0, 2047));
      cycle();
      if (obs_v[0]) begin
        ca++;
        chk("mute_zero", 0, 32'(ol[0]) | 32'(orr[0]), 0);
      end
    end
    chk("mute_strobes", 0, ca, 10);
    mute[0] = 1'b0;
    repeat (100) begin
      mixl[0] = 11'($urandom_range(0, 2047));
      cycle();
    end

    // Reset while a sample sits in S2: dropped, then a fresh PRIME
    found = 0;
    for (int i = 0; i < 30; i++) begin
      cycle();
      if (mtick[0]) begin found = 1; break; end
    end
    chk("tick_found", 0, found, 1);
    rst[0] = 1'b1;
    cycle();
    rst[0] = 1'b0;
    ca = 0;
    repeat (20) begin cycle(); if (obs_v[0]) ca++; end
    chk("reprime_no_strobe", 0, ca, 0);

    // Randomised run: held random mixes, mute toggles, rare resets
    for (int i = 0; i < 2000; i++) begin
      for (int d = 0; d < 2; d++) begin
        if ($urandom_range(0, 7) == 0) begin
          mixl[d] = 11'($urandom_range(0, 2047));
          mixr[d] = 11'($urandom_range(0, 2047));
        end
        if ($urandom_range(0, 63) == 0) mute[d] = ~mute[d];
        rst[d] = ($urandom_range(0, 299) == 0);
      end
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
